// File: rtl/pipelined_prefix_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_prefix_adder_if
//
// Purpose: groups the operand-side and result-side valid/ready handshakes of
//          pipelined_prefix_adder into one bundle.
//
// Signals:
//   in_valid / in_ready  operand beat handshake (producer -> adder)
//   a, b                 WIDTH-bit operands
//   cin                  carry-in (ignored when sub=1)
//   sub                  1 = a - b, 0 = a + b + cin
//   out_valid / out_ready result beat handshake (adder -> consumer)
//   sum                  WIDTH-bit result
//   cout, ovf, zero      carry out of MSB, signed overflow, sum == 0
//
// Modports:
//   master  the surrounding datapath (drives operands, accepts results)
//   slave   the adder itself
// -----------------------------------------------------------------------------
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// -----------------------------------------------------------------------------
// pipelined_prefix_adder
//
// Purpose: pipelined Kogge-Stone parallel-prefix adder/subtractor with
//          valid/ready flow control on both sides. Feeds the ALU result mux
//          from the execute stage; sustains one beat per cycle when the
//          consumer is not applying back-pressure.
//
// Parameters:
//   WIDTH  operand/result width, power of two, 8..64
//   PIPE   register stages from input accept to output, 1..clog2(WIDTH)+1
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    pipelined_prefix_adder_if.slave (operands, result, handshakes)
//
// Configuration macro:
//   ADDER_FLAGS_EN  when defined, cout/ovf/zero are computed and registered
//                   with the sum; otherwise they are tied to 0 and their
//                   registers do not exist.
// -----------------------------------------------------------------------------
module pipelined_prefix_adder #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    pipelined_prefix_adder_if.slave bus
);

    localparam int LEVELS = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    // Applies Kogge-Stone levels lo..hi-1 (distances 2**lo .. 2**(hi-1)).
    // Levels outside that window pass through, so each pipeline stage can
    // call it with its own slice of the tree.
    function automatic gp_t prefix_levels(gp_t x, int lo, int hi);
        gp_t cur;
        gp_t nxt;
        cur = x;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            nxt = cur;
            if (lvl >= lo && lvl < hi) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (i >= (1 << lvl)) begin
                        nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[i - (1 << lvl)]);
                        nxt.p[i] = cur.p[i] & cur.p[i - (1 << lvl)];
                    end
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    // -------------------------------------------------------------------------
    // Stage inputs: index 0 is the operand port, index k>0 is register k-1.
    // -------------------------------------------------------------------------
    gp_t              in_gp [PIPE];
    logic [WIDTH-1:0] in_x  [PIPE];   // a ^ b_eff, kept for the final sum
    logic             in_c0 [PIPE];   // effective carry-in, carry[0]
    logic [PIPE-1:0]  in_v;           // valid arriving at each stage

    logic [PIPE-1:0]  valid_q;
    logic [PIPE-1:0]  en;             // stage k may load this cycle

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    gp_t              gp0;

    // NOTE: always_comb gives every variable a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        b_eff    = bus.sub ? ~bus.b : bus.b;
        c0       = bus.sub | bus.cin;
        gp0.g    = bus.a & b_eff;
        gp0.p    = bus.a ^ b_eff;
        // Carry-in folded in as a generate from position -1: bit 0 then
        // produces the true carry out of bit 0 and the tree needs no extra level.
        gp0.g[0] = gp0.g[0] | (gp0.p[0] & c0);
    end

    assign in_gp[0] = gp0;
    assign in_x[0]  = bus.a ^ b_eff;
    assign in_c0[0] = c0;

    always_comb begin
        in_v[0] = bus.in_valid;
        for (int k = 1; k < PIPE; k++) begin
            in_v[k] = valid_q[k-1];
        end
    end

    // Ready chain from the output back to the input: a stage can load when it
    // is empty or its current beat is moving on this same cycle. This lets a
    // full pipe accept and drain in one cycle.
    always_comb begin
        logic leave;
        leave = bus.out_ready;
        en    = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            leave = !valid_q[k] || leave;
            en[k] = leave;
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = valid_q[PIPE-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge clk or posedge reset) begin : p_valid
        if (reset) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (en[k]) begin
                    valid_q[k] <= in_v[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stages. Stage k covers tree levels [k*LEVELS/PIPE, (k+1)*LEVELS/PIPE);
    // the last stage also forms the sum and flags.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
`ifdef ADDER_FLAGS_EN
    logic cout_d, ovf_d, zero_d;
    logic cout_q, ovf_q, zero_q;
`endif

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int LO = (k * LEVELS) / PIPE;
        localparam int HI = ((k + 1) * LEVELS) / PIPE;

        gp_t gp_d;
        assign gp_d = prefix_levels(in_gp[k], LO, HI);

        if (k < PIPE - 1) begin : g_mid
            gp_t              gp_q;
            logic [WIDTH-1:0] x_q;
            logic             c0_q;

            // NOTE: datapath registers carry no reset; the valid bits qualify
            // them, so their power-up contents are never observed.
            always_ff @(posedge clk) begin
                if (en[k] && in_v[k]) begin
                    gp_q <= gp_d;
                    x_q  <= in_x[k];
                    c0_q <= in_c0[k];
                end
            end

            assign in_gp[k+1] = gp_q;
            assign in_x[k+1]  = x_q;
            assign in_c0[k+1] = c0_q;
        end else begin : g_last
            logic unused_ok;

            // carry[i] = group generate of bits i-1..0 (with c0), carry[0] = c0.
            assign sum_d = in_x[k] ^ {gp_d.g[WIDTH-2:0], in_c0[k]};
`ifdef ADDER_FLAGS_EN
            assign cout_d    = gp_d.g[WIDTH-1];
            // Overflow: carry into MSB differs from carry out of MSB.
            assign ovf_d     = gp_d.g[WIDTH-1] ^ gp_d.g[WIDTH-2];
            assign zero_d    = ~|sum_d;
            assign unused_ok = ^gp_d.p;
`else
            assign unused_ok = ^{gp_d.p, gp_d.g[WIDTH-1]};
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin : p_out
        if (reset) begin
            sum_q  <= '0;
`ifdef ADDER_FLAGS_EN
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
`endif
        end else if (en[PIPE-1] && in_v[PIPE-1]) begin
            sum_q  <= sum_d;
`ifdef ADDER_FLAGS_EN
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
`endif
        end
    end

    assign bus.sum = sum_q;
`ifdef ADDER_FLAGS_EN
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.cout = 1'b0;
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule
